// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared encodings for the MIPS multi-cycle control unit:
//               opcode/func constants, FSM state codes, datapath mux selects
//               and the one-hot instruction-class record.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] c_fn_nop   = 6'h00;
    localparam logic [5:0] c_fn_jr    = 6'h08;
    localparam logic [5:0] c_fn_addu  = 6'h21;
    localparam logic [5:0] c_fn_subu  = 6'h23;

    // FSM state codes; 6 and 7 are unused and recover to FETCH
    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_trap   = 3'd5;

    // Next-PC select
    localparam logic [1:0] c_npc_pc4 = 2'd0;
    localparam logic [1:0] c_npc_br  = 2'd1;
    localparam logic [1:0] c_npc_jmp = 2'd2;
    localparam logic [1:0] c_npc_rs  = 2'd3;

    // Register-file destination select
    localparam logic [1:0] c_dst_rt = 2'd0;
    localparam logic [1:0] c_dst_rd = 2'd1;
    localparam logic [1:0] c_dst_ra = 2'd2;

    // Write-back source select
    localparam logic [1:0] c_wb_alu = 2'd0;
    localparam logic [1:0] c_wb_mem = 2'd1;
    localparam logic [1:0] c_wb_pc  = 2'd2;

    // Immediate extension mode
    localparam logic [1:0] c_ext_zero = 2'd0;
    localparam logic [1:0] c_ext_sign = 2'd1;
    localparam logic [1:0] c_ext_lui  = 2'd2;

    // ALU function (3 is reserved)
    localparam logic [1:0] c_alu_add = 2'd0;
    localparam logic [1:0] c_alu_sub = 2'd1;
    localparam logic [1:0] c_alu_or  = 2'd2;

    // One-hot instruction class; all zero for an illegal encoding
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic nop;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } instr_cls_t;

    // True for the instructions that make a data-memory access
    function automatic logic is_mem(input instr_cls_t cls);
        return cls.lw | cls.sw;
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_decode.sv
`default_nettype none
// ============================================================================
// Module      : mips_decode
// Description : Combinational op/func decoder producing a one-hot instruction
//               class and an illegal-encoding flag. Shared with the future
//               pipelined control path.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_decode
    import mips_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [5:0]  i_func,
    output instr_cls_t  o_cls,
    output logic        o_illegal
);

    // Map op (and func for R-type) onto exactly one class bit, or flag illegal
    always_comb begin
        o_cls     = '0;
        o_illegal = 1'b0;
        case (i_op)
            c_op_rtype: begin
                case (i_func)
                    c_fn_addu: o_cls.addu = 1'b1;
                    c_fn_subu: o_cls.subu = 1'b1;
                    c_fn_jr:   o_cls.jr   = 1'b1;
                    c_fn_nop:  o_cls.nop  = 1'b1;
                    default:   o_illegal  = 1'b1;
                endcase
            end
            c_op_ori: o_cls.ori = 1'b1;
            c_op_lui: o_cls.lui = 1'b1;
            c_op_lw:  o_cls.lw  = 1'b1;
            c_op_sw:  o_cls.sw  = 1'b1;
            c_op_beq: o_cls.beq = 1'b1;
            c_op_j:   o_cls.j   = 1'b1;
            c_op_jal: o_cls.jal = 1'b1;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule : mips_decode
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_ctrl
// Description : Multi-cycle MIPS control unit. Steps each instruction through
//               FETCH/DECODE/EXEC/MEM/WB, waits on the memory ready handshake,
//               traps illegal encodings and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int MEM_HS  = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               iord,
    output logic               ir_wr,
    output logic               pc_wr,
    output logic [1:0]         npc_sel,
    output logic               reg_wr,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wb_sel,
    output logic               alu_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         ext_op,
    output logic [2:0]         state,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    logic [2:0]       r_state;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    logic [2:0]       w_state_nxt;
    logic             w_retire;
    logic             w_ready;
    instr_cls_t       w_cls;
    logic             w_dec_illegal;

    logic             w_mem_rd;
    logic             w_mem_wr;
    logic             w_iord;
    logic             w_ir_wr;
    logic             w_pc_wr;
    logic [1:0]       w_npc_sel;
    logic             w_reg_wr;
    logic [1:0]       w_reg_dst;
    logic [1:0]       w_wb_sel;
    logic             w_alu_src;
    logic [1:0]       w_alu_op;
    logic [1:0]       w_ext_op;

    mips_decode u_decode (
        .i_op      (op),
        .i_func    (func),
        .o_cls     (w_cls),
        .o_illegal (w_dec_illegal)
    );

    // With the handshake disabled every access completes in one cycle
    assign w_ready = (MEM_HS != 0) ? mem_ready : 1'b1;

    // Next-state selection and retirement pulse
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        case (r_state)
            c_st_fetch: begin
                if (w_ready) begin
                    w_state_nxt = c_st_decode;
                end
            end
            c_st_decode: begin
                if (w_dec_illegal) begin
                    w_state_nxt = c_st_trap;
                end else if (w_cls.j || w_cls.jal || w_cls.jr || w_cls.nop) begin
                    w_retire    = 1'b1;
                    w_state_nxt = c_st_fetch;
                end else begin
                    w_state_nxt = c_st_exec;
                end
            end
            c_st_exec: begin
                if (w_cls.beq) begin
                    w_retire    = 1'b1;
                    w_state_nxt = c_st_fetch;
                end else if (is_mem(w_cls)) begin
                    w_state_nxt = c_st_mem;
                end else if (w_cls.addu || w_cls.subu || w_cls.ori || w_cls.lui) begin
                    w_state_nxt = c_st_wb;
                end else begin
                    w_state_nxt = c_st_fetch;
                end
            end
            c_st_mem: begin
                if (w_ready) begin
                    if (w_cls.sw) begin
                        w_retire    = 1'b1;
                        w_state_nxt = c_st_fetch;
                    end else if (w_cls.lw) begin
                        w_state_nxt = c_st_wb;
                    end else begin
                        w_state_nxt = c_st_fetch;
                    end
                end
            end
            c_st_wb: begin
                w_retire    = 1'b1;
                w_state_nxt = c_st_fetch;
            end
            c_st_trap: begin
                w_state_nxt = c_st_trap;
            end
            default: begin
                w_state_nxt = c_st_fetch;
            end
        endcase
    end

    // Datapath strobes and selects; all held low while reset is asserted
    always_comb begin
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_iord    = 1'b0;
        w_ir_wr   = 1'b0;
        w_pc_wr   = 1'b0;
        w_npc_sel = c_npc_pc4;
        w_reg_wr  = 1'b0;
        w_reg_dst = c_dst_rt;
        w_wb_sel  = c_wb_alu;
        w_alu_src = 1'b0;
        w_alu_op  = c_alu_add;
        w_ext_op  = c_ext_zero;
        if (!reset) begin
            case (r_state)
                c_st_fetch: begin
                    w_mem_rd = 1'b1;
                    if (w_ready) begin
                        w_ir_wr = 1'b1;
                        w_pc_wr = 1'b1;
                    end
                end
                c_st_decode: begin
                    if (w_cls.j || w_cls.jal) begin
                        w_pc_wr   = 1'b1;
                        w_npc_sel = c_npc_jmp;
                    end
                    if (w_cls.jal) begin
                        w_reg_wr  = 1'b1;
                        w_reg_dst = c_dst_ra;
                        w_wb_sel  = c_wb_pc;
                    end
                    if (w_cls.jr) begin
                        w_pc_wr   = 1'b1;
                        w_npc_sel = c_npc_rs;
                    end
                end
                c_st_exec: begin
                    if (w_cls.subu) begin
                        w_alu_op = c_alu_sub;
                    end
                    if (w_cls.ori) begin
                        w_alu_op  = c_alu_or;
                        w_alu_src = 1'b1;
                    end
                    if (w_cls.lui) begin
                        w_alu_src = 1'b1;
                        w_ext_op  = c_ext_lui;
                    end
                    if (is_mem(w_cls)) begin
                        w_alu_src = 1'b1;
                        w_ext_op  = c_ext_sign;
                    end
                    if (w_cls.beq) begin
                        w_alu_op  = c_alu_sub;
                        w_ext_op  = c_ext_sign;
                        w_pc_wr   = zero;
                        w_npc_sel = c_npc_br;
                    end
                end
                c_st_mem: begin
                    // Combinational from IR and state only, so stable across waits
                    w_iord   = 1'b1;
                    w_mem_rd = w_cls.lw;
                    w_mem_wr = w_cls.sw;
                end
                c_st_wb: begin
                    w_reg_wr = 1'b1;
                    if (w_cls.addu || w_cls.subu) begin
                        w_reg_dst = c_dst_rd;
                    end
                    if (w_cls.lw) begin
                        w_wb_sel = c_wb_mem;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, sticky trap flag and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_fetch;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == c_st_trap) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign mem_rd  = w_mem_rd;
    assign mem_wr  = w_mem_wr;
    assign iord    = w_iord;
    assign ir_wr   = w_ir_wr;
    assign pc_wr   = w_pc_wr;
    assign npc_sel = w_npc_sel;
    assign reg_wr  = w_reg_wr;
    assign reg_dst = w_reg_dst;
    assign wb_sel  = w_wb_sel;
    assign alu_src = w_alu_src;
    assign alu_op  = ALUOP_W'(w_alu_op);
    assign ext_op  = w_ext_op;
    assign state   = r_state;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule : mips_mc_ctrl
`default_nettype wire
